pipelined_adder: RTL and testbench

//  Parametrised, pipelined WIDTH-bit adder with carry-in/carry-out and valid/ready handshakes on both sides.
//  The operand is split into STAGES equal chunks; each pipeline stage adds one chunk with a ripple of full-adder cells.
//  The carry is registered between stages, giving one result per clock at full throughput.
//  It is the datapath adder for wide accumulators and counters, replacing single-bit combinational full adders.

---
 rtl/adder_pkg.sv | 16 +
 rtl/adder_chunk.sv | 28 ++
 rtl/pipelined_adder.sv | 144 ++++++++++++++
 tb/tb_pipelined_adder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared configuration helpers for the pipelined adder: chunk width and parameter legality.
// Latency: none (elaboration-time functions only).
// Backpressure: not applicable.
package adder_pkg;

  // Width of the slice each pipeline stage adds; guarded so a bad STAGES cannot divide by zero.
  function automatic int chunk_w(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  // A legal configuration splits the operand into 1..width equal, non-empty chunks.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit ripple of full-adder cells with carry in and carry out.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the enclosing stage register decides when the result is captured.
module adder_chunk
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co
);

  logic carry;

  // Ripple the carry through one full-adder cell per bit, LSB first.
  always_comb begin
    carry = ci;
    s     = '0;
    for (int i = 0; i < CW; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit a+b+cin split into STAGES chunk adders with the carry registered between stages.
// Latency: STAGES cycles (operands taken at edge N are on sum/cout after edge N+STAGES-1).
// Backpressure: one global advance; out_ready low with out_valid high freezes every stage and drops in_ready.
// Optional: define ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  import adder_pkg::*;

  localparam int CW = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $fatal(1, "pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  // Whole-pipe advance: move when the output slot is empty or being drained.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Index 0 is the input side; index s+1 is what stage s registered.
  logic             pv [STAGES+1];
  logic [WIDTH-1:0] ps [STAGES+1];
  logic             pc [STAGES+1];
  // Operand skew: only stages that still have chunks left to add forward operands.
  logic [WIDTH-1:0] pa [STAGES];
  logic [WIDTH-1:0] pb [STAGES];
`ifdef ADDER_OVF_EN
  logic [WIDTH-1:0] pn [STAGES];
`endif

  assign pv[0] = in_valid;
  assign ps[0] = '0;
  assign pc[0] = cin;
  assign pa[0] = a;
  assign pb[0] = b;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [CW-1:0]    chunk_s;
    logic             chunk_co;
    logic [WIDTH-1:0] sum_nxt;
    logic             vld_q;
    logic             c_q;
    logic [WIDTH-1:0] s_q;

    adder_chunk #(.CW(CW)) u_chunk (
      .a  (pa[s][s*CW +: CW]),
      .b  (pb[s][s*CW +: CW]),
      .ci (pc[s]),
      .s  (chunk_s),
      .co (chunk_co)
    );

    // Splice this stage's freshly computed chunk into the running partial sum.
    always_comb begin
      sum_nxt               = ps[s];
      sum_nxt[s*CW +: CW]   = chunk_s;
    end

`ifdef ADDER_OVF_EN
    assign pn[s] = sum_nxt;
`endif

    // Stage register: valid, partial sum and carry move together so back-to-back ops never mix.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        s_q   <= '0;
        c_q   <= 1'b0;
      end else if (adv) begin
        vld_q <= pv[s];
        s_q   <= sum_nxt;
        c_q   <= chunk_co;
      end
    end

    assign pv[s+1] = vld_q;
    assign ps[s+1] = s_q;
    assign pc[s+1] = c_q;

    if (s < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      // Carry the operands forward so later stages see the chunks they still have to add.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= pa[s];
          b_q <= pb[s];
        end
      end

      assign pa[s+1] = a_q;
      assign pb[s+1] = b_q;
    end
  end

  assign out_valid = pv[STAGES];
  assign sum       = ps[STAGES];
  assign cout      = pc[STAGES];

`ifdef ADDER_OVF_EN
  logic ovf_nxt;
  logic ovf_q;

  // Sign bits come from the top operand chunk that the last stage is adding.
  assign ovf_nxt = (pa[STAGES-1][WIDTH-1] == pb[STAGES-1][WIDTH-1]) &&
                   (pn[STAGES-1][WIDTH-1] != pa[STAGES-1][WIDTH-1]);

  // Overflow flag registered alongside the last stage so it lines up with sum/cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_nxt;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder at WIDTH=16, STAGES=4.
// Drives and samples on the falling edge; results are compared as {ovf,cout,sum}.
// ovf is compared only when ADDER_OVF_EN is defined.
module tb_pipelined_adder;

  localparam int W  = 16;
  localparam int ST = 4;
`ifdef ADDER_OVF_EN
  localparam logic [17:0] M = 18'h3FFFF;
`else
  localparam logic [17:0] M = 18'h1FFFF;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  function automatic logic [17:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [16:0] t;
    t = {1'b0, x} + {1'b0, y} + {16'd0, c};
    return {(x[15] == y[15]) && (t[15] != x[15]), t};
  endfunction

  // Drive one cycle on the falling edge and report the handshakes that the next rising edge will complete.
  task automatic step(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                      input logic ordy, output logic acc, output logic dlv, output logic [17:0] obs);
    @(negedge clk);
    in_valid  = v;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    dlv = out_valid && out_ready;
`ifdef ADDER_OVF_EN
    obs = {ovf, cout, sum};
`else
    obs = {1'b0, cout, sum};
`endif
  endtask

  task automatic test_reset();
    logic acc, dlv;
    logic [17:0] obs;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b1, acc, dlv, obs);
      checks++;
      if (out_valid !== 1'b0 || (obs & M) !== 18'h0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: out_valid=%b ovf/cout/sum=%h, want 0 and 00000", i, out_valid, obs & M);
      end
    end
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b, want 1", in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, dlv, obs);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_ghost cycle %0d: out_valid=%b, want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_single();
    logic acc, dlv, want;
    logic [17:0] obs;
    step(1'b1, 16'h1234, 16'h0FCD, 1'b1, 1'b1, acc, dlv, obs);
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: accepted=%b, want 1", acc);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, dlv, obs);
      want = (i == 3);
      checks++;
      if (out_valid !== want) begin
        errors++;
        $display("FAIL single_latency cycle %0d: out_valid=%b, want %b", i, out_valid, want);
      end
      if (i == 3) begin
        checks++;
        if ((obs & M) !== (18'h02202 & M)) begin
          errors++;
          $display("FAIL single_sum: ovf/cout/sum=%h, want %h", obs & M, 18'h02202 & M);
        end
      end
    end
  endtask

  task automatic test_carry();
    logic acc, dlv;
    logic [17:0] obs, e;
    int got = 0;
    exp_q.delete();
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, acc, dlv, obs);
    if (acc) exp_q.push_back(18'h10000);
    step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, acc, dlv, obs);
    if (acc) exp_q.push_back(18'h30000);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, dlv, obs);
      if (dlv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL carry_extra: unexpected result %h", obs & M);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ((obs & M) !== (e & M)) begin
            errors++;
            $display("FAIL carry_result %0d: ovf/cout/sum=%h, want %h", got, obs & M, e & M);
          end
        end
      end
    end
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL carry_count: delivered %0d, want 2", got);
    end
  endtask

  task automatic test_streaming();
    logic acc, dlv;
    logic [17:0] obs, e;
    logic [W-1:0] na, nb;
    logic nc;
    int issued = 0, got = 0, first = -1, gaps = 0;
    exp_q.delete();
    na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
    for (int c = 0; c < 200 && got < 100; c++) begin
      step(issued < 100, na, nb, nc, 1'b1, acc, dlv, obs);
      if (acc) begin
        exp_q.push_back(model(na, nb, nc));
        issued++;
        na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
      end
      if (dlv) begin
        if (first < 0) first = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: unexpected result %h", obs & M);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ((obs & M) !== (e & M)) begin
            errors++;
            $display("FAIL stream_result %0d: ovf/cout/sum=%h, want %h", got, obs & M, e & M);
          end
        end
      end else if (first >= 0) begin
        gaps++;
      end
    end
    checks++;
    if (got != 100) begin
      errors++;
      $display("FAIL stream_count: delivered %0d, want 100", got);
    end
    checks++;
    if (first != ST) begin
      errors++;
      $display("FAIL stream_fill: first result at cycle %0d, want %0d", first, ST);
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL stream_gaps: %0d idle cycles after fill, want 0", gaps);
    end
  endtask

  task automatic test_backpressure();
    logic acc, dlv, ordy;
    logic [17:0] obs, e;
    logic [W-1:0] ta [8];
    logic [W-1:0] tb [8];
    int issued = 0, got = 0, stalls = 0;
    ta = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h1357, 16'hF0F0, 16'h00FF, 16'hAAAA};
    tb = '{16'h0002, 16'h0001, 16'h0001, 16'hFFFF, 16'h2468, 16'h0F0F, 16'hFF01, 16'h5556};
    exp_q.delete();
    for (int c = 0; c < 40; c++) begin
      ordy = !(c >= 6 && c < 11);
      step(issued < 8, ta[issued % 8], tb[issued % 8], issued[0], ordy, acc, dlv, obs);
      if (!ordy && out_valid) begin
        stalls++;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready cycle %0d: in_ready=%b, want 0", c, in_ready);
        end
      end
      if (acc) begin
        exp_q.push_back(model(ta[issued], tb[issued], issued[0]));
        issued++;
      end
      if (dlv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: duplicate or unexpected result %h", obs & M);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ((obs & M) !== (e & M)) begin
            errors++;
            $display("FAIL bp_result %0d: ovf/cout/sum=%h, want %h", got, obs & M, e & M);
          end
        end
      end
    end
    checks++;
    if (got != 8 || stalls != 5) begin
      errors++;
      $display("FAIL bp_count: delivered %0d stalled %0d, want 8 and 5", got, stalls);
    end
  endtask

  task automatic test_reset_mid();
    logic acc, dlv;
    logic [17:0] obs, e;
    int got = 0, want_n = 1;
    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1, acc, dlv, obs);
    step(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b1, acc, dlv, obs);
    step(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b1, acc, dlv, obs);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, dlv, obs);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_ghost cycle %0d: out_valid=%b, want 0", i, out_valid);
      end
    end
    step(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1, acc, dlv, obs);
    if (acc) exp_q.push_back(18'h00002);
`ifdef ADDER_OVF_EN
    want_n = 3;
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, acc, dlv, obs);
    if (acc) exp_q.push_back(18'h28000);
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, acc, dlv, obs);
    if (acc) exp_q.push_back(18'h10000);
`endif
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, dlv, obs);
      if (dlv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL midreset_extra: unexpected result %h", obs & M);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ((obs & M) !== (e & M)) begin
            errors++;
            $display("FAIL midreset_result %0d: ovf/cout/sum=%h, want %h", got, obs & M, e & M);
          end
        end
      end
    end
    checks++;
    if (got != want_n) begin
      errors++;
      $display("FAIL midreset_count: delivered %0d, want %0d", got, want_n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_carry();
    test_streaming();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
